// File: rtl/accel_pkg.sv
// Shared widths and FSM state encoding for the tilt controller slice.
package accel_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned POS_W    = 10;
  localparam int unsigned ARITH_W  = 11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_APPLY
  } state_t;

endpackage

// File: rtl/accel_sample_avg.sv
// Periodic, stability-gated capture of the raw Y byte and a sliding-window average.
module accel_sample_avg
  import accel_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 50000,
  parameter int unsigned AVG_LOG2   = 2,
  parameter bit          INVERT     = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] received_y,
  output logic [SAMPLE_W-1:0] avg_y,
  output logic                sample_strobe
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = SAMPLE_W + AVG_LOG2;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SAMPLE_DIV - 1);

  logic [SAMPLE_W-1:0]        y_s1_q, y_s2_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       pending_q;
  logic signed [SAMPLE_W-1:0] samp_q;
  logic signed [SAMPLE_W-1:0] win_q [DEPTH];
  logic signed [SUM_W-1:0]    sum_q, sum_d, sum_shift;
  logic signed [SAMPLE_W-1:0] cond_y;
  logic                       accept;

  always_comb begin
    // The SPI side has no valid strobe, so only take a value seen twice in a row.
    accept = pending_q && (y_s1_q == y_s2_q);
    cond_y = $signed(y_s2_q);
    if (INVERT) begin
      cond_y = (y_s2_q == 8'h80) ? 8'sd127 : -$signed(y_s2_q);
    end
    sum_d     = sum_q + SUM_W'(samp_q) - SUM_W'(win_q[DEPTH-1]);
    sum_shift = sum_q >>> AVG_LOG2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_s1_q        <= '0;
      y_s2_q        <= '0;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      samp_q        <= '0;
      sum_q         <= '0;
      avg_y         <= '0;
      sample_strobe <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      y_s1_q <= received_y;
      y_s2_q <= y_s1_q;
      cnt_q  <= (cnt_q == CntLast) ? '0 : cnt_q + CNT_W'(1);

      // A terminal count while still pending is absorbed, never queued.
      if (accept) begin
        pending_q <= 1'b0;
      end else if (cnt_q == CntLast) begin
        pending_q <= 1'b1;
      end

      sample_strobe <= accept;
      if (accept) begin
        samp_q <= cond_y;
      end

      if (sample_strobe) begin
        sum_q    <= sum_d;
        win_q[0] <= samp_q;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          win_q[i] <= win_q[i-1];
        end
      end

      avg_y <= sum_shift[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/accel_tilt_controller.sv
// Turns the averaged Y tilt into a dead-zoned, clamped ship X position updated once per frame.
module accel_tilt_controller
  import accel_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 50000,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned DEAD_ZONE  = 8,
  parameter int unsigned SHIFT      = 3,
  parameter int unsigned MAX_STEP   = 8,
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 600,
  parameter int unsigned X_INIT     = 300,
  parameter bit          INVERT     = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] received_y,
  input  logic                frame_tick,
  input  logic                enable,
  output logic [POS_W-1:0]    ship_x,
  output logic                dir_left,
  output logic                dir_right,
  output logic [SAMPLE_W-1:0] avg_y,
  output logic                sample_strobe
);

  state_t               state_q;
  logic [ARITH_W-1:0]   step_q;
  logic                 left_q;
  logic [POS_W-1:0]     ship_x_q;
  logic                 dir_left_q, dir_right_q;

  logic [SAMPLE_W:0]    avg_ext, mag;
  logic [ARITH_W-1:0]   raw_step, step_c, x_ext, next_x;

  accel_sample_avg #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .AVG_LOG2   (AVG_LOG2),
    .INVERT     (INVERT)
  ) u_sample_avg (
    .clk           (clk),
    .reset         (reset),
    .received_y    (received_y),
    .avg_y         (avg_y),
    .sample_strobe (sample_strobe)
  );

  always_comb begin
    avg_ext  = {avg_y[SAMPLE_W-1], avg_y};
    mag      = avg_y[SAMPLE_W-1] ? ((SAMPLE_W+1)'(0) - avg_ext) : avg_ext;
    raw_step = '0;
    step_c   = '0;
    if (mag > (SAMPLE_W+1)'(DEAD_ZONE)) begin
      raw_step = ARITH_W'((mag - (SAMPLE_W+1)'(DEAD_ZONE)) >> SHIFT) + ARITH_W'(1);
      step_c   = (raw_step > ARITH_W'(MAX_STEP)) ? ARITH_W'(MAX_STEP) : raw_step;
    end

    // Widened by one bit so the right-hand sum cannot wrap before the clamp compare.
    x_ext = {1'b0, ship_x_q};
    if (left_q) begin
      next_x = (x_ext < ARITH_W'(X_MIN) + step_q) ? ARITH_W'(X_MIN) : x_ext - step_q;
    end else begin
      next_x = (x_ext + step_q > ARITH_W'(X_MAX)) ? ARITH_W'(X_MAX) : x_ext + step_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      left_q      <= 1'b0;
      ship_x_q    <= POS_W'(X_INIT);
      dir_left_q  <= 1'b0;
      dir_right_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_tick && enable) begin
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          step_q  <= step_c;
          left_q  <= avg_y[SAMPLE_W-1];
          state_q <= S_APPLY;
        end
        S_APPLY: begin
          if (enable) begin
            ship_x_q    <= next_x[POS_W-1:0];
            dir_left_q  <= left_q && (step_q != '0);
            dir_right_q <= !left_q && (step_q != '0);
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ship_x    = ship_x_q;
  assign dir_left  = dir_left_q && enable;
  assign dir_right = dir_right_q && enable;

endmodule

// File: tb/tb_accel_tilt_controller.sv
// Randomised and directed bench for accel_tilt_controller against a behavioural model.
module tb_accel_tilt_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_y = 8'h00;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b1;
  logic [9:0] ship_x;
  logic       dir_left, dir_right;
  logic [7:0] avg_y;
  logic       sample_strobe;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accel_tilt_controller #(
    .SAMPLE_DIV (16)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .received_y    (received_y),
    .frame_tick    (frame_tick),
    .enable        (enable),
    .ship_x        (ship_x),
    .dir_left      (dir_left),
    .dir_right     (dir_right),
    .avg_y         (avg_y),
    .sample_strobe (sample_strobe)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: history of the last two input bytes, a queue window,
  // and the position rules computed with plain integer arithmetic.
  int m_s1, m_s2, m_cnt, m_pend, m_strobe, m_samp;
  int m_win[$];
  int m_sum, m_avg, m_phase, m_step, m_left, m_ship, m_dl, m_dr;

  function automatic int sx8(input int b);
    return (b >= 128) ? b - 256 : b;
  endfunction

  function automatic int floor4(input int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  function automatic int step_of(input int a);
    int mag, s;
    mag = (a < 0) ? -a : a;
    if (mag <= 8) return 0;
    s = (mag - 8) / 8 + 1;
    return (s > 8) ? 8 : s;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_cnt = 0; m_pend = 0; m_strobe = 0; m_samp = 0;
    m_win = '{0, 0, 0, 0};
    m_sum = 0; m_avg = 0; m_phase = 0; m_step = 0; m_left = 0;
    m_ship = 300; m_dl = 0; m_dr = 0;
  endtask

  task automatic model_edge(input int y, input bit tick, input bit en, input bit rst);
    int acc, n_avg, n_phase;
    if (rst) begin
      model_reset();
      return;
    end
    acc   = (m_pend != 0) && (m_s1 == m_s2);
    n_avg = floor4(m_sum);
    n_phase = m_phase;
    case (m_phase)
      0: if (tick && en) n_phase = 1;
      1: begin
        m_step = step_of(m_avg);
        m_left = (m_avg < 0);
        n_phase = 2;
      end
      default: begin
        if (en) begin
          if (m_left) m_ship = (m_ship - m_step < 0) ? 0 : m_ship - m_step;
          else        m_ship = (m_ship + m_step > 600) ? 600 : m_ship + m_step;
          m_dl = m_left && (m_step != 0);
          m_dr = !m_left && (m_step != 0);
        end
        n_phase = 0;
      end
    endcase
    if (m_strobe != 0) begin
      m_win.push_front(m_samp);
      void'(m_win.pop_back());
      m_sum = 0;
      foreach (m_win[i]) m_sum += m_win[i];
    end
    if (acc) begin
      m_pend = 0;
      m_samp = sx8(m_s2);
    end else if (m_cnt == 15) begin
      m_pend = 1;
    end
    m_cnt    = (m_cnt + 1) % 16;
    m_strobe = acc;
    m_avg    = n_avg;
    m_phase  = n_phase;
    m_s2     = m_s1;
    m_s1     = y;
  endtask

  task automatic cycle(input logic [7:0] y, input bit tick, input bit en, input bit rst);
    @(negedge clk);
    received_y = y;
    frame_tick = tick;
    enable     = en;
    reset      = rst;
    @(posedge clk);
    #1;
    model_edge(int'(y), tick, en, rst);
    check_eq("sample_strobe", int'(sample_strobe), m_strobe);
    check_eq("avg_y", int'($signed(avg_y)), m_avg);
    check_eq("ship_x", int'(ship_x), m_ship);
    check_eq("dir_left", int'(dir_left), int'(m_dl && en));
    check_eq("dir_right", int'(dir_right), int'(m_dr && en));
  endtask

  task automatic frame(input logic [7:0] y);
    cycle(y, 1'b1, 1'b1, 1'b0);
    cycle(y, 1'b0, 1'b1, 1'b0);
    cycle(y, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int strobes, first_idx, cur;
    logic [7:0] ty;

    model_reset();
    // 1: reset state
    cycle(8'h00, 1'b0, 1'b1, 1'b1);
    cycle(8'h00, 1'b0, 1'b1, 1'b1);
    check_eq("rst_ship_x", int'(ship_x), 300);
    check_eq("rst_avg_y", int'(avg_y), 0);
    check_eq("rst_dirs", int'({dir_left, dir_right}), 0);
    check_eq("rst_strobe", int'(sample_strobe), 0);

    // 2: steady +64 tilt, one right step of 8
    repeat (90) cycle(8'h40, 1'b0, 1'b1, 1'b0);
    check_eq("avg_pos64", int'($signed(avg_y)), 64);
    frame(8'h40);
    check_eq("ship_right_step", int'(ship_x), 308);
    check_eq("dir_right_set", int'(dir_right), 1);

    // 3: -8 sits inside the dead zone
    repeat (90) cycle(8'hF8, 1'b0, 1'b1, 1'b0);
    check_eq("avg_neg8", int'($signed(avg_y)), -8);
    frame(8'hF8);
    check_eq("ship_deadzone", int'(ship_x), 308);
    check_eq("dirs_deadzone", int'({dir_left, dir_right}), 0);

    // 4: full left tilt walks to 4, then clamps at 0 and holds
    repeat (90) cycle(8'h80, 1'b0, 1'b1, 1'b0);
    check_eq("avg_min", int'($signed(avg_y)), -128);
    repeat (38) frame(8'h80);
    check_eq("ship_preset4", int'(ship_x), 4);
    frame(8'h80);
    check_eq("ship_clamp_left", int'(ship_x), 0);
    frame(8'h80);
    check_eq("ship_hold_left", int'(ship_x), 0);
    check_eq("dir_left_at_bound", int'(dir_left), 1);

    // 5: toggling input never yields a sample; first stable pair does
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      ty = (i % 2 == 1) ? 8'h55 : 8'hAA;
      cycle(ty, 1'b0, 1'b1, 1'b0);
      strobes += int'(sample_strobe);
    end
    check_eq("toggle_no_strobe", strobes, 0);
    first_idx = -1;
    for (int j = 0; j < 6; j++) begin
      cycle(8'h55, 1'b0, 1'b1, 1'b0);
      if (sample_strobe && first_idx < 0) first_idx = j;
    end
    check_eq("strobe_after_stable", first_idx, 1);

    // Frame ticks with enable low are ignored
    cycle(8'h55, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(8'h55, 1'b0, 1'b0, 1'b0);
    check_eq("disabled_tick_ship", int'(ship_x), 0);

    // 6: reset while in S_STEP aborts the step
    cycle(8'h55, 1'b1, 1'b1, 1'b0);
    cycle(8'h55, 1'b0, 1'b1, 1'b1);
    check_eq("abort_ship_x", int'(ship_x), 300);
    repeat (4) cycle(8'h55, 1'b0, 1'b1, 1'b0);
    check_eq("abort_no_step", int'(ship_x), 300);

    // Random soak
    cur = 8'h30;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) cur = int'($urandom_range(0, 255));
      ty = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'(cur);
      cycle(ty, $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 999) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
